// File: rtl/nibble_add_sequencer_pkg.sv
// Shared types and helpers for the nibble-serial add sequencer:
// FSM state encodings, default slice count and the round-robin pick.
package nibble_add_sequencer_pkg;

  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One-hot winner; on a tie the requester that did not win last time goes first
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Requester-facing bundle of the add sequencer: two operand pairs in,
// grant/done handshake and registered result out.
interface nibble_add_sequencer_if
  import nibble_add_sequencer_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
);
  localparam int W = 4 * NIBBLES;

  logic [1:0]   req;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [1:0]   gnt;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, sum, cout
  );

endinterface

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry slice shared by both requesters.
module nibble_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_add_sequencer.sv
// Round-robin controller that time-shares one 4-bit adder slice, feeding
// latched operands through it one nibble per cycle, LSB first.
module nibble_add_sequencer
  import nibble_add_sequencer_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input logic                  clk,
  input logic                  rst,
  nibble_add_sequencer_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               carry_r, carry_s;
  logic               last_r, last_s;
  logic               cur_id_r, cur_id_s;
  logic [W-1:0]       a_r, a_s;
  logic [W-1:0]       b_r, b_s;
  logic [W-1:0]       acc_r, acc_s;
  logic [W-1:0]       merged_s;
  logic [1:0]         gnt_r, gnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               done_id_r, done_id_s;
  logic [W-1:0]       sum_r, sum_s;
  logic               cout_r, cout_s;
  logic [1:0]         pick_s;
  logic               win_s;
  logic [3:0]         slice_a_s, slice_b_s, slice_sum_s;
  logic               slice_co_s;

  assign slice_a_s = a_r[{idx_r, 2'b00} +: 4];
  assign slice_b_s = b_r[{idx_r, 2'b00} +: 4];

  nibble_adder4 u_slice (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_co_s)
  );

  // Next-state and next-output computation for the controller FSM
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    carry_s   = carry_r;
    last_s    = last_r;
    cur_id_s  = cur_id_r;
    a_s       = a_r;
    b_s       = b_r;
    acc_s     = acc_r;
    gnt_s     = 2'b00;
    busy_s    = busy_r;
    done_s    = 1'b0;
    done_id_s = done_id_r;
    sum_s     = sum_r;
    cout_s    = cout_r;
    pick_s    = rr_pick(bus.req, last_r);
    win_s     = pick_s[1];
    merged_s  = acc_r;
    merged_s[{idx_r, 2'b00} +: 4] = slice_sum_s;

    case (state_r)
      S_IDLE: begin
        if (pick_s != 2'b00) begin
          a_s      = win_s ? bus.a1 : bus.a0;
          b_s      = win_s ? bus.b1 : bus.b0;
          carry_s  = 1'b0;
          idx_s    = '0;
          gnt_s    = pick_s;
          cur_id_s = win_s;
          last_s   = win_s;
          state_s  = S_RUN;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        // busy rises one cycle after gnt so the two never overlap
        busy_s  = 1'b1;
        acc_s   = merged_s;
        carry_s = slice_co_s;
        idx_s   = idx_r + IDX_W'(1);
        if (idx_r == IDX_LAST) begin
          state_s   = S_DONE;
          done_s    = 1'b1;
          sum_s     = merged_s;
          cout_s    = slice_co_s;
          done_id_s = cur_id_r;
        end else begin
          state_s   = S_RUN;
        end
      end
      S_DONE: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any add in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      idx_r     <= '0;
      carry_r   <= 1'b0;
      last_r    <= 1'b1;
      cur_id_r  <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      acc_r     <= '0;
      gnt_r     <= 2'b00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      carry_r   <= carry_s;
      last_r    <= last_s;
      cur_id_r  <= cur_id_s;
      a_r       <= a_s;
      b_r       <= b_s;
      acc_r     <= acc_s;
      gnt_r     <= gnt_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      done_id_r <= done_id_s;
      sum_r     <= sum_s;
      cout_r    <= cout_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench: table of single adds, then arbitration, operand-change,
// mid-run reset and a two-nibble instance.
module tb_nibble_add_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nibble_add_sequencer_if #(.NIBBLES(4)) if4 ();
  nibble_add_sequencer_if #(.NIBBLES(2)) if2 ();

  nibble_add_sequencer #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  nibble_add_sequencer #(.NIBBLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt4(output int n);
    n = 0;
    while (if4.gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (if4.done == 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_add(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum, input logic exp_cout, input string tag);
    int n;
    logic [1:0] exp_g;
    exp_g = id ? 2'b10 : 2'b01;
    @(negedge clk);
    if (id) begin
      if4.a1 = a;
      if4.b1 = b;
    end else begin
      if4.a0 = a;
      if4.b0 = b;
    end
    if4.req = exp_g;
    wait_gnt4(n);
    check({tag, "_gnt"}, 32'(if4.gnt), 32'(exp_g));
    check({tag, "_busy_at_gnt"}, 32'(if4.busy), 32'd0);
    if4.req = 2'b00;
    wait_done4(n);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_sum"}, 32'(if4.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(if4.cout), 32'(exp_cout));
    check({tag, "_id"}, 32'(if4.done_id), 32'(id));
    check({tag, "_busy_at_done"}, 32'(if4.busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(if4.done), 32'd0);
    check({tag, "_busy_after"}, 32'(if4.busy), 32'd0);
    check({tag, "_sum_hold"}, 32'(if4.sum), 32'(exp_sum));
  endtask

  initial begin
    int n;
    int gcount;
    int dcount;
    int dones;
    logic [1:0] gseq[4];
    logic last_gid;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
    vecs[5] = '{1'b1, 16'hABCD, 16'h1234, 16'hBE01, 1'b0};
    gseq[0] = 2'b01;
    gseq[1] = 2'b10;
    gseq[2] = 2'b01;
    gseq[3] = 2'b10;

    if4.req = 2'b00; if4.a0 = 16'h0; if4.b0 = 16'h0; if4.a1 = 16'h0; if4.b1 = 16'h0;
    if2.req = 2'b00; if2.a0 = 8'h0;  if2.b0 = 8'h0;  if2.a1 = 8'h0;  if2.b1 = 8'h0;
    do_reset();

    check("rst_gnt",     32'(if4.gnt),     32'd0);
    check("rst_busy",    32'(if4.busy),    32'd0);
    check("rst_done",    32'(if4.done),    32'd0);
    check("rst_done_id", 32'(if4.done_id), 32'd0);
    check("rst_sum",     32'(if4.sum),     32'd0);
    check("rst_cout",    32'(if4.cout),    32'd0);

    for (int i = 0; i < 6; i++) begin
      run_add(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout,
              $sformatf("vec%0d", i));
    end

    // Sustained dual requests from reset: 0,1,0,1
    do_reset();
    if4.a0 = 16'h0001; if4.b0 = 16'h0001;
    if4.a1 = 16'h0002; if4.b1 = 16'h0002;
    if4.req = 2'b11;
    gcount = 0;
    dcount = 0;
    last_gid = 1'b0;
    for (int c = 0; c < 100 && dcount < 4; c++) begin
      @(negedge clk);
      if (if4.gnt != 2'b00) begin
        check($sformatf("rr_gnt%0d", gcount), 32'(if4.gnt), 32'(gseq[gcount % 4]));
        check($sformatf("rr_busy_gnt%0d", gcount), 32'(if4.busy), 32'd0);
        last_gid = if4.gnt[1];
        gcount++;
      end
      if (if4.done) begin
        check($sformatf("rr_id%0d", dcount), 32'(if4.done_id), 32'(last_gid));
        check($sformatf("rr_sum%0d", dcount), 32'(if4.sum), last_gid ? 32'h4 : 32'h2);
        dcount++;
      end
    end
    if4.req = 2'b00;
    check("rr_dones", 32'(dcount), 32'd4);
    check("rr_grants", 32'(gcount), 32'd4);

    // Operand and request changes during RUN are ignored
    @(negedge clk);
    if4.a0 = 16'h00F0; if4.b0 = 16'h0010; if4.req = 2'b01;
    wait_gnt4(n);
    check("chg_gnt", 32'(if4.gnt), 32'd1);
    if4.req = 2'b10; if4.a0 = 16'hAAAA; if4.a1 = 16'h5555; if4.b1 = 16'h1111;
    @(negedge clk);
    check("chg_nogntA", 32'(if4.gnt), 32'd0);
    if4.req = 2'b11; if4.a0 = 16'hFFFF; if4.b0 = 16'hFFFF;
    @(negedge clk);
    check("chg_nogntB", 32'(if4.gnt), 32'd0);
    if4.req = 2'b00;
    wait_done4(n);
    check("chg_latency", 32'(n), 32'd2);
    check("chg_sum", 32'(if4.sum), 32'h0100);
    check("chg_cout", 32'(if4.cout), 32'd0);
    check("chg_id", 32'(if4.done_id), 32'd0);
    @(negedge clk);
    check("chg_no_extra_gnt", 32'(if4.gnt), 32'd0);

    // Reset while idx==2 aborts the add
    @(negedge clk);
    if4.a0 = 16'h1234; if4.b0 = 16'h1111; if4.req = 2'b01;
    wait_gnt4(n);
    check("mrst_gnt", 32'(if4.gnt), 32'd1);
    if4.req = 2'b00;
    repeat (2) @(negedge clk);
    check("mrst_busy_before", 32'(if4.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_sum",  32'(if4.sum),  32'd0);
    check("mrst_busy", 32'(if4.busy), 32'd0);
    check("mrst_done", 32'(if4.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if4.done) dones++;
    end
    check("mrst_no_done", 32'(dones), 32'd0);
    run_add(1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, "post_rst");

    // Two-nibble instance
    @(negedge clk);
    if2.a0 = 8'hFF; if2.b0 = 8'hFF; if2.req = 2'b01;
    n = 0;
    while (if2.gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("n2_gnt", 32'(if2.gnt), 32'd1);
    if2.req = 2'b00;
    n = 0;
    while (if2.done == 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("n2_latency", 32'(n), 32'd2);
    check("n2_sum", 32'(if2.sum), 32'hFE);
    check("n2_cout", 32'(if2.cout), 32'd1);
    check("n2_id", 32'(if2.done_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
